// File: rtl/mt_pkg.sv
// Shared constants, per-width configuration and FSM encoding for the
// Mersenne Twister stream generator family.
package mt_pkg;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } mt_state_e;

    localparam logic [63:0] MT_DEFAULT_SEED = 64'd5489;

    typedef struct packed {
        int unsigned n;
        int unsigned m;
        int unsigned r;
        int unsigned u;
        int unsigned s;
        int unsigned t;
        int unsigned l;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] f;
    } mt_cfg_t;

    // MT19937
    localparam int unsigned MT32_N = 624;
    localparam int unsigned MT32_M = 397;
    localparam int unsigned MT32_R = 31;
    localparam int unsigned MT32_U = 11;
    localparam int unsigned MT32_S = 7;
    localparam int unsigned MT32_T = 15;
    localparam int unsigned MT32_L = 18;
    localparam logic [63:0] MT32_A = 64'h0000_0000_9908_B0DF;
    localparam logic [63:0] MT32_D = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] MT32_B = 64'h0000_0000_9D2C_5680;
    localparam logic [63:0] MT32_C = 64'h0000_0000_EFC6_0000;
    localparam logic [63:0] MT32_F = 64'd1812433253;

    // MT19937-64
    localparam int unsigned MT64_N = 312;
    localparam int unsigned MT64_M = 156;
    localparam int unsigned MT64_R = 31;
    localparam int unsigned MT64_U = 29;
    localparam int unsigned MT64_S = 17;
    localparam int unsigned MT64_T = 37;
    localparam int unsigned MT64_L = 43;
    localparam logic [63:0] MT64_A = 64'hB502_6F5A_A966_19E9;
    localparam logic [63:0] MT64_D = 64'h5555_5555_5555_5555;
    localparam logic [63:0] MT64_B = 64'h71D6_7FFF_EDA6_0000;
    localparam logic [63:0] MT64_C = 64'hFFF7_EEE0_0000_0000;
    localparam logic [63:0] MT64_F = 64'd6364136223846793005;

    // Illegal widths fall back to the 32-bit set; the top rejects them.
    function automatic mt_cfg_t mt_cfg(input int w);
        mt_cfg_t c;
        if (w == 64) begin
            c = '{n: MT64_N, m: MT64_M, r: MT64_R, u: MT64_U, s: MT64_S,
                  t: MT64_T, l: MT64_L, a: MT64_A, d: MT64_D, b: MT64_B,
                  c: MT64_C, f: MT64_F};
        end else begin
            c = '{n: MT32_N, m: MT32_M, r: MT32_R, u: MT32_U, s: MT32_S,
                  t: MT32_T, l: MT32_L, a: MT32_A, d: MT32_D, b: MT32_B,
                  c: MT32_C, f: MT32_F};
        end
        return c;
    endfunction

endpackage

// File: rtl/mt_temper.sv
// Combinational Mersenne Twister output tempering for the selected width.
module mt_temper
    import mt_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] x_in,
    output logic [W-1:0] x_out
);

    localparam mt_cfg_t CFG = mt_cfg(W);
    localparam int U = int'(CFG.u);
    localparam int S = int'(CFG.s);
    localparam int T = int'(CFG.t);
    localparam int L = int'(CFG.l);
    localparam logic [W-1:0] D_C = CFG.d[W-1:0];
    localparam logic [W-1:0] B_C = CFG.b[W-1:0];
    localparam logic [W-1:0] C_C = CFG.c[W-1:0];

    logic [W-1:0] t1, t2, t3;

    always_comb begin
        t1    = x_in ^ ((x_in >> U) & D_C);
        t2    = t1 ^ ((t1 << S) & B_C);
        t3    = t2 ^ ((t2 << T) & C_C);
        x_out = t3 ^ (t3 >> L);
    end

endmodule

// File: rtl/mt_stream_gen.sv
// Mersenne Twister generator (W=32 or 64) with a seeding FSM and a
// valid/ready output stream that never drops or repeats a word.
module mt_stream_gen
    import mt_pkg::*;
#(
    parameter int          W            = 32,
    parameter logic [63:0] DEFAULT_SEED = MT_DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] seed,
    input  logic         re_seed,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rnd
);

    localparam mt_cfg_t CFG = mt_cfg(W);
    localparam int N  = int'(CFG.n);
    localparam int M  = int'(CFG.m);
    localparam int R  = int'(CFG.r);
    localparam int IW = $clog2(N);

    localparam logic [W-1:0] A_C   = CFG.a[W-1:0];
    localparam logic [W-1:0] F_C   = CFG.f[W-1:0];
    localparam logic [W-1:0] LOWER = (W'(1) << R) - W'(1);
    localparam logic [W-1:0] UPPER = ~LOWER;
    localparam logic [W-1:0] SEED0 = DEFAULT_SEED[W-1:0];

    if (!(W == 32 || W == 64)) begin : g_bad_width
        $error("mt_stream_gen: W must be 32 or 64");
    end

    logic [W-1:0]  mem_q [N];
    mt_state_e     state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [W-1:0]  seed0_q, seed0_d;
    logic [W-1:0]  rnd_q, rnd_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;

    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [IW-1:0] ip1, ipm;
    logic [W-1:0]  rd_a, rd_b;
    logic [W-1:0]  y, x_new, x_seed, x_temp;

    // ptr_q is idx while seeding and i while running. cur_q holds x[idx-1]
    // during SEED and x[i] during RUN; seed0_q keeps x[0] until RUN starts.
    always_comb begin
        ip1    = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + 1'b1;
        ipm    = (ptr_q >= IW'(N - M)) ? ptr_q - IW'(N - M) : ptr_q + IW'(M);
        rd_a   = mem_q[ip1];
        rd_b   = mem_q[ipm];
        x_seed = F_C * (cur_q ^ (cur_q >> (W - 2))) + W'(ptr_q);
        y      = (cur_q & UPPER) | (rd_a & LOWER);
        x_new  = rd_b ^ (y >> 1) ^ (y[0] ? A_C : '0);
    end

    mt_temper #(.W(W)) u_temper (
        .x_in  (x_new),
        .x_out (x_temp)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        seed0_d = seed0_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = x_new;
        if (re_seed) begin
            state_d = ST_SEED;
            ptr_d   = IW'(1);
            cur_d   = seed;
            seed0_d = seed;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    wr_en   = 1'b1;
                    wr_data = x_seed;
                    cur_d   = x_seed;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == IW'(N - 1)) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                        cur_d   = seed0_q;
                        busy_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!valid_q || out_ready) begin
                        wr_en   = 1'b1;
                        cur_d   = rd_a;
                        rnd_d   = x_temp;
                        valid_d = 1'b1;
                        ptr_d   = ip1;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SEED;
            ptr_q   <= IW'(1);
            cur_q   <= SEED0;
            seed0_q <= SEED0;
            rnd_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            seed0_q <= seed0_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // State array carries no reset; every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign rnd       = rnd_q;

endmodule

// File: tb/tb_mt_stream_gen.sv
// Directed bench for mt_stream_gen: golden words, seeding latency, stalls,
// re_seed corner cases and asynchronous reset, against a batch MT19937 model.
module tb_mt_stream_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] seed32;
    logic        re_seed32;
    logic        busy32, valid32, ready32;
    logic [31:0] rnd32;
    logic [63:0] seed64;
    logic        re_seed64;
    logic        busy64, valid64, ready64;
    logic [63:0] rnd64;

    mt_stream_gen #(.W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .seed(seed32), .re_seed(re_seed32),
        .busy(busy32), .out_valid(valid32), .out_ready(ready32), .rnd(rnd32)
    );

    mt_stream_gen #(.W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .seed(seed64), .re_seed(re_seed64),
        .busy(busy64), .out_valid(valid64), .out_ready(ready64), .rnd(rnd64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference MT19937 in the classic batch-twist form.
    logic [31:0] mt [624];
    int          mti;

    task automatic m_init(input logic [31:0] s);
        mt[0] = s;
        for (int i = 1; i < 624; i++)
            mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
        mti = 624;
    endtask

    task automatic m_next(output logic [31:0] r);
        logic [31:0] y;
        if (mti >= 624) begin
            for (int k = 0; k < 624; k++) begin
                y = (mt[k] & 32'h8000_0000) | (mt[(k + 1) % 624] & 32'h7FFF_FFFF);
                mt[k] = mt[(k + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'h0);
            end
            mti = 0;
        end
        y = mt[mti];
        mti++;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C_5680);
        y = y ^ ((y << 15) & 32'hEFC6_0000);
        y = y ^ (y >> 18);
        r = y;
    endtask

    logic [63:0] cap32 [10001];
    logic [63:0] cap64 [10001];
    int          t_busy, t_valid, t64_busy, t64_valid;
    int          got, n64;
    logic [31:0] first_word;

    // Called on the negedge right after the seeding posedge (count 0).
    task automatic run_stream(input int max_cyc, input int n_words, input bit rnd_ready,
                              input bit track64);
        int          cyc;
        bit          seq_ok, stall_ok, stall_pending;
        logic [31:0] stall_rnd, e;
        int          f0;
        cyc = 0; got = 0; n64 = 0;
        t_busy = -1; t_valid = -1; t64_busy = -1; t64_valid = -1;
        seq_ok = 1; stall_ok = 1; stall_pending = 0; stall_rnd = '0;
        while ((got < n_words || (track64 && n64 < 10000)) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (t_busy < 0 && !busy32) t_busy = cyc;
            if (t_valid < 0 && valid32) t_valid = cyc;
            if (t64_busy < 0 && !busy64) t64_busy = cyc;
            if (t64_valid < 0 && valid64) t64_valid = cyc;
            if (track64 && valid64 && n64 < 10000) begin
                n64++;
                cap64[n64] = rnd64;
            end
            if (stall_pending && stall_ok) begin
                f0 = n_fail;
                chk("stall_hold_valid", {63'd0, valid32}, 64'd1);
                chk("stall_hold_rnd", {32'd0, rnd32}, {32'd0, stall_rnd});
                if (n_fail != f0) stall_ok = 0;
            end
            ready32 = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid32 && ready32 && got < n_words) begin
                m_next(e);
                got++;
                if (got == 1) first_word = rnd32;
                if (got <= 10000) cap32[got] = {32'd0, rnd32};
                if (seq_ok) begin
                    f0 = n_fail;
                    chk("stream_vs_model", {32'd0, rnd32}, {32'd0, e});
                    if (n_fail != f0) seq_ok = 0;
                end
                stall_pending = 0;
            end else if (valid32) begin
                stall_pending = 1;
                stall_rnd     = rnd32;
            end else begin
                stall_pending = 0;
            end
        end
        chk("words_received", 64'(got), 64'(n_words));
    endtask

    typedef struct {
        bit          w64;
        int          idx;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{0, 1,     64'd3499211612};
        tbl[1] = '{0, 2,     64'd581869302};
        tbl[2] = '{0, 3,     64'd3890346734};
        tbl[3] = '{0, 4,     64'd3586334585};
        tbl[4] = '{0, 5,     64'd545404204};
        tbl[5] = '{0, 10000, 64'd4123659995};
        tbl[6] = '{1, 1,     64'd14514284786278117030};
        tbl[7] = '{1, 10000, 64'd9981545732273789042};

        rst_n = 1'b0; seed32 = '0; re_seed32 = 1'b0; ready32 = 1'b1;
        seed64 = '0; re_seed64 = 1'b0; ready64 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy32}, 64'd1);
        chk("reset_valid", {63'd0, valid32}, 64'd0);
        chk("reset_rnd", {32'd0, rnd32}, 64'd0);
        chk("reset_valid64", {63'd0, valid64}, 64'd0);

        // Free run from the default seed, both widths.
        rst_n = 1'b1;
        m_init(32'd5489);
        run_stream(11000, 10000, 1'b0, 1'b1);
        chk("busy_fall_cycle", 64'(t_busy), 64'd623);
        chk("first_valid_cycle", 64'(t_valid), 64'd624);
        chk("busy64_fall_cycle", 64'(t64_busy), 64'd311);
        chk("first_valid64_cycle", 64'(t64_valid), 64'd312);
        chk("words64_received", 64'(n64), 64'd10000);
        for (int v = 0; v < 8; v++)
            chk(tbl[v].w64 ? "golden64" : "golden32",
                tbl[v].w64 ? cap64[tbl[v].idx] : cap32[tbl[v].idx], tbl[v].exp);

        // Mid-stream re_seed to the default seed, then random back-pressure.
        re_seed32 = 1'b1; seed32 = 32'd5489;
        m_init(32'd5489);
        @(negedge clk);
        re_seed32 = 1'b0;
        chk("reseed_valid_drop", {63'd0, valid32}, 64'd0);
        chk("reseed_busy", {63'd0, busy32}, 64'd1);
        run_stream(8000, 1500, 1'b1, 1'b0);
        chk("reseed_first_valid", 64'(t_valid), 64'd624);
        chk("reseed_busy_fall", 64'(t_busy), 64'd623);
        chk("reseed_first_word", {32'd0, first_word}, 64'd3499211612);

        // re_seed while seeding, near idx 300.
        re_seed32 = 1'b1; seed32 = 32'h1234_5678;
        @(negedge clk);
        re_seed32 = 1'b0;
        repeat (299) @(negedge clk);
        chk("midseed_busy", {63'd0, busy32}, 64'd1);
        re_seed32 = 1'b1; seed32 = 32'h0BAD_F00D;
        m_init(32'h0BAD_F00D);
        @(negedge clk);
        re_seed32 = 1'b0;
        run_stream(2000, 3, 1'b0, 1'b0);
        chk("midseed_first_valid", 64'(t_valid), 64'd624);

        // The third word handshakes on the same posedge that samples re_seed.
        chk("hs_valid_before", {63'd0, valid32 & ready32}, 64'd1);
        re_seed32 = 1'b1; seed32 = 32'hCAFE_0042;
        m_init(32'hCAFE_0042);
        @(negedge clk);
        re_seed32 = 1'b0;
        chk("hs_reseed_valid_drop", {63'd0, valid32}, 64'd0);
        chk("hs_reseed_busy", {63'd0, busy32}, 64'd1);
        run_stream(2000, 5, 1'b1, 1'b0);
        chk("hs_reseed_first_valid", 64'(t_valid), 64'd624);

        // Asynchronous reset while a word is pending.
        ready32 = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", {63'd0, valid32}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {63'd0, valid32}, 64'd0);
        chk("async_reset_rnd", {32'd0, rnd32}, 64'd0);
        chk("async_reset_busy", {63'd0, busy32}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_init(32'd5489);
        run_stream(2000, 5, 1'b1, 1'b0);
        chk("post_reset_first_valid", 64'(t_valid), 64'd624);
        chk("post_reset_first_word", {32'd0, first_word}, 64'd3499211612);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
